mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the opcode decoder. Holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents the fetched instruction, its PC+4 and its opcode field to the decode stage over a valid/ready handshake. Resolved branch/jump outcomes (BranchEqual, BranchNotEqual, Jump plus the ALU zero flag) are fed back to redirect the PC and squash wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset (bits [1:0] must be 0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  32  word-aligned fetch address, stable while imem_req=1
imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  in  32  instruction word, valid only with imem_ack
if_valid  out  1  if_instr/if_pc_plus4/if_opcode valid for decode
id_ready  in  1  decode accepts when if_valid & id_ready
if_instr  out  32  fetched instruction
if_opcode  out  6  if_instr[31:26], feeds decoder
if_pc_plus4  out  32  address of if_instr + 4
res_valid  in  1  resolution of one control-flow instruction this cycle
res_beq  in  1  BranchEqual of resolved instruction
res_bne  in  1  BranchNotEqual of resolved instruction
res_jump  in  1  Jump (J/JAL) of resolved instruction
res_zero  in  1  ALU zero flag of resolved instruction
res_pc_plus4  in  32  PC+4 of resolved instruction
res_imm  in  16  immediate field of resolved branch
res_target  in  26  target field of resolved jump
redirect  out  1  combinational: taken redirect this cycle (for upstream flush)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, if_valid=0, if_instr=0, if_pc_plus4=0, redirect=0. Reset mid-request abandons it; an imem_ack after reset release is ignored unless in FETCH.
- taken = res_valid & ((res_beq & res_zero) | (res_bne & ~res_zero) | res_jump); redirect=taken.
- Target: res_jump -> {res_pc_plus4[31:28], res_target, 2'b00}; else res_pc_plus4 + {{14{res_imm[15]}}, res_imm, 2'b00}. 32-bit modulo arithmetic; jump wins if both jump and branch set.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). imem_addr=pc; bits [1:0] always 0.
- States: IDLE, FETCH, HOLD, DISCARD.
- IDLE: imem_req=0; next FETCH (one cycle after reset release). taken -> pc=target.
- FETCH: imem_req=1. ack & ~taken -> latch if_instr=imem_rdata, if_pc_plus4=pc+4, pc=pc+4, if_valid=1, -> HOLD. ack & taken -> drop data, pc=target, stay FETCH (new req next cycle with new addr; req may drop for 0 cycles, addr changes only after ack). ~ack & taken -> pc_pending=target, -> DISCARD.
- DISCARD: imem_req=1 at old addr until ack; data dropped; on ack -> FETCH with pc=latest target. Further taken in DISCARD overwrites pending target.
- HOLD: if_valid=1, outputs stable. taken (regardless of id_ready) -> if_valid=0, pc=target, -> FETCH. id_ready & ~taken -> if_valid=0, -> FETCH next cycle (pc already advanced).
- Latency: ack in cycle N -> if_valid in N+1; handshake in cycle M -> imem_req for next word in M+1. Throughput 1 instr / 2 cycles minimum with single-cycle memory.
- if_opcode is always if_instr[31:26]; decoder output is don't-care while if_valid=0.
- res_valid=1 with no branch/jump bits set -> no effect.

Decomposition:
- Package mips_defs: opcode constants (OP_RTYPE 6'b000000, OP_J 6'b000010, OP_JAL 6'b000011, OP_BEQ 6'b000100, OP_BNE 6'b000101), fetch state enum (2-bit), RESET_PC default.
- One sub-module: mips_next_pc — combinational taken/target computation from res_* inputs; top holds FSM and registers.

Test Plan:
- Reset release, imem_ack 1 cycle after every req, id_ready=1 -> addrs 0,4,8,C issued; if_valid pulses with if_pc_plus4=4,8,C,10; if_opcode=imem_rdata[31:26].
- HOLD with id_ready=0 for 5 cycles -> if_valid, if_instr stable, imem_req=0; id_ready=1 -> next req addr=pc+4 next cycle.
- BEQ resolve: res_pc_plus4=32'h0000_0010, res_imm=16'hFFFC, res_zero=1 -> redirect=1, next imem_addr=32'h0000_0000; same with res_zero=0 -> no redirect.
- JAL resolve while in FETCH without ack: res_pc_plus4=32'h4000_0004, res_target=26'h000_0100 -> old ack dropped (if_valid stays 0), next req addr=32'h4000_0400.
- Redirect same cycle as ack -> if_valid stays 0, next addr=target; redirect in HOLD with id_ready=1 -> instruction not handed over.
- RESET_PC=32'hFFFF_FFFC -> second fetch addr 32'h0000_0000; rst_n low mid-FETCH -> imem_req=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/mips_fetch_unit_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: opcode field values,
// fetch FSM state encoding and the default reset PC.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/mips_fetch_unit_next_pc.sv
// Redirect decision and target address for one resolved control-flow instruction.
module mips_next_pc (
    input  logic        res_valid,
    input  logic        res_beq,
    input  logic        res_bne,
    input  logic        res_jump,
    input  logic        res_zero,
    input  logic [31:0] res_pc_plus4,
    input  logic [15:0] res_imm,
    input  logic [25:0] res_target,
    output logic        taken,
    output logic [31:0] target_pc
);

    logic [31:0] branch_off;

    always_comb begin
        branch_off = {{14{res_imm[15]}}, res_imm, 2'b00};
        taken      = res_valid & ((res_beq & res_zero) | (res_bne & ~res_zero) | res_jump);
        // A jump takes precedence when the resolver flags both kinds.
        if (res_jump)
            target_pc = {res_pc_plus4[31:28], res_target, 2'b00};
        else
            target_pc = res_pc_plus4 + branch_off;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch from instruction memory, valid/ready
// hand-off to decode, and redirect on resolved branches/jumps.
//
// state   | meaning
// IDLE    | one cycle after reset, no request
// FETCH   | request outstanding at pc
// HOLD    | instruction presented to decode, waiting for id_ready
// DISCARD | wrong-path request still outstanding, data will be dropped
module mips_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc_plus4,
    input  logic        res_valid,
    input  logic        res_beq,
    input  logic        res_bne,
    input  logic        res_jump,
    input  logic        res_zero,
    input  logic [31:0] res_pc_plus4,
    input  logic [15:0] res_imm,
    input  logic [25:0] res_target,
    output logic        redirect
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  pc_pending, pc_pending_nxt;
    logic [31:0]  instr_q, instr_nxt;
    logic [31:0]  pc4_q, pc4_nxt;
    logic         taken;
    logic [31:0]  target_pc;

    mips_next_pc u_next_pc (
        .res_valid    (res_valid),
        .res_beq      (res_beq),
        .res_bne      (res_bne),
        .res_jump     (res_jump),
        .res_zero     (res_zero),
        .res_pc_plus4 (res_pc_plus4),
        .res_imm      (res_imm),
        .res_target   (res_target),
        .taken        (taken),
        .target_pc    (target_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pc_pending <= RESET_PC;
            instr_q    <= '0;
            pc4_q      <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pc_pending <= pc_pending_nxt;
            instr_q    <= instr_nxt;
            pc4_q      <= pc4_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pc_pending_nxt = pc_pending;
        instr_nxt      = instr_q;
        pc4_nxt        = pc4_q;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (taken) pc_nxt = target_pc;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (taken) begin
                        pc_nxt = target_pc;
                    end else begin
                        instr_nxt = imem_rdata;
                        pc4_nxt   = pc_inc(pc);
                        pc_nxt    = pc_inc(pc);
                        state_nxt = HOLD;
                    end
                end else if (taken) begin
                    // Address must stay stable until ack, so park the target.
                    pc_pending_nxt = target_pc;
                    state_nxt      = DISCARD;
                end
            end
            DISCARD: begin
                if (taken) pc_pending_nxt = target_pc;
                if (imem_ack) begin
                    pc_nxt    = taken ? target_pc : pc_pending;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (taken) begin
                    pc_nxt    = target_pc;
                    state_nxt = FETCH;
                end else if (id_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_req    = (state == FETCH) || (state == DISCARD);
    assign imem_addr   = {pc[31:2], 2'b00};
    assign if_valid    = (state == HOLD);
    assign if_instr    = instr_q;
    assign if_opcode   = instr_q[31:26];
    assign if_pc_plus4 = pc4_q;
    assign redirect    = taken;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit with queue-based scoreboards for fetch acks
// and decode hand-offs, plus a second instance exercising PC wrap-around.
module tb_mips_fetch_unit;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } hand_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req, imem_ack, if_valid, id_ready, redirect;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc_plus4;
    logic [5:0]  if_opcode;
    logic        res_valid, res_beq, res_bne, res_jump, res_zero;
    logic [31:0] res_pc_plus4;
    logic [15:0] res_imm;
    logic [25:0] res_target;

    logic        mem_auto, auto_ack, man_ack;

    logic        req2, valid2, redirect2;
    logic [31:0] addr2, instr2, pc4_2;
    logic [5:0]  opcode2;

    int          total = 0;
    int          bad = 0;
    int          hand_cnt = 0;
    logic [31:0] exp_ack[$];
    hand_t       exp_hand[$];
    logic [31:0] log2[$];
    logic [31:0] first_pc4_2;
    logic        got_pc4_2 = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2], a[27:2]};
    endfunction

    assign imem_ack   = mem_auto ? auto_ack : man_ack;
    assign imem_rdata = mem_word(imem_addr);

    mips_fetch_unit u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .id_ready     (id_ready),
        .if_instr     (if_instr),
        .if_opcode    (if_opcode),
        .if_pc_plus4  (if_pc_plus4),
        .res_valid    (res_valid),
        .res_beq      (res_beq),
        .res_bne      (res_bne),
        .res_jump     (res_jump),
        .res_zero     (res_zero),
        .res_pc_plus4 (res_pc_plus4),
        .res_imm      (res_imm),
        .res_target   (res_target),
        .redirect     (redirect)
    );

    mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (req2),
        .imem_addr    (addr2),
        .imem_ack     (req2),
        .imem_rdata   (mem_word(addr2)),
        .if_valid     (valid2),
        .id_ready     (1'b1),
        .if_instr     (instr2),
        .if_opcode    (opcode2),
        .if_pc_plus4  (pc4_2),
        .res_valid    (1'b0),
        .res_beq      (1'b0),
        .res_bne      (1'b0),
        .res_jump     (1'b0),
        .res_zero     (1'b0),
        .res_pc_plus4 (32'h0),
        .res_imm      (16'h0),
        .res_target   (26'h0),
        .redirect     (redirect2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_res(input logic v, input logic beq, input logic bne, input logic jmp,
                           input logic z, input logic [31:0] pc4, input logic [15:0] imm,
                           input logic [25:0] tgt);
        res_valid    = v;
        res_beq      = beq;
        res_bne      = bne;
        res_jump     = jmp;
        res_zero     = z;
        res_pc_plus4 = pc4;
        res_imm      = imm;
        res_target   = tgt;
    endtask

    task automatic push_hand(input logic [31:0] addr);
        hand_t h;
        h.pc4   = addr + 32'd4;
        h.instr = mem_word(addr);
        exp_hand.push_back(h);
    endtask

    // Memory model: acks one cycle after the request is first seen.
    initial begin
        int wcnt;
        auto_ack = 1'b0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                if (wcnt >= 1) begin
                    auto_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    auto_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                auto_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a fetch or hand-off.
    initial begin
        logic [31:0] a;
        hand_t h;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imem_req && imem_ack) begin
                    if (exp_ack.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack actual addr=%h required none", imem_addr);
                    end else begin
                        a = exp_ack.pop_front();
                        check("ack_addr", imem_addr, a);
                    end
                end
                if (if_valid && id_ready && !redirect) begin
                    hand_cnt++;
                    if (exp_hand.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_handoff actual pc4=%h required none", if_pc_plus4);
                    end else begin
                        h = exp_hand.pop_front();
                        check("hand_pc4", if_pc_plus4, h.pc4);
                        check("hand_instr", if_instr, h.instr);
                        check("hand_opcode", {26'h0, if_opcode}, {26'h0, h.instr[31:26]});
                    end
                end
                if (req2 && log2.size() < 2) log2.push_back(addr2);
                if (valid2 && !got_pc4_2) begin
                    first_pc4_2 = pc4_2;
                    got_pc4_2   = 1'b1;
                end
            end
        end
    end

    initial begin
        logic found;
        logic [31:0] vec_pc4  [3] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
        logic        vec_beq  [3] = '{1'b1, 1'b0, 1'b0};
        logic        vec_bne  [3] = '{1'b0, 1'b1, 1'b0};
        logic        vec_zero [3] = '{1'b0, 1'b1, 1'b1};

        rst_n    = 1'b0;
        id_ready = 1'b1;
        mem_auto = 1'b1;
        man_ack  = 1'b0;
        set_res(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        repeat (3) cyc();
        neg();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_redirect", {31'h0, redirect}, 32'h0);

        // Streaming fetch with a one-cycle memory and decode always ready.
        for (int i = 0; i < 5; i++) exp_ack.push_back(32'(i * 4));
        for (int i = 0; i < 4; i++) push_hand(32'(i * 4));
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 80 && hand_cnt < 4; i++) cyc();
        check("stream_count", hand_cnt, 4);
        id_ready = 1'b0;

        // Decode stalls: instruction must be held stable with no new request.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            neg();
            found = if_valid;
        end
        check("hold_reached", {31'h0, found}, 32'h1);
        check("hold_instr0", if_instr, mem_word(32'h10));
        check("hold_pc4", if_pc_plus4, 32'h14);
        for (int i = 0; i < 5; i++) begin
            cyc();
            neg();
            check("hold_valid", {31'h0, if_valid}, 32'h1);
            check("hold_instr", if_instr, mem_word(32'h10));
            check("hold_noreq", {31'h0, imem_req}, 32'h0);
        end
        cyc();
        mem_auto = 1'b0;
        id_ready = 1'b1;
        push_hand(32'h10);
        neg();
        cyc();
        neg();
        check("next_req", {31'h0, imem_req}, 32'h1);
        check("next_addr", imem_addr, 32'h14);

        // Resolutions that must not redirect.
        for (int i = 0; i < 3; i++) begin
            cyc();
            set_res(1, vec_beq[i], vec_bne[i], 0, vec_zero[i], vec_pc4[i], 16'hFFFC, 26'h0);
            neg();
            check("nottaken_redirect", {31'h0, redirect}, 32'h0);
        end
        cyc();
        set_res(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        neg();
        check("nottaken_addr", imem_addr, 32'h14);

        // JAL while the request is outstanding: old data dropped, then jump target.
        cyc();
        set_res(1, 0, 0, 1, 0, 32'h4000_0004, 16'h0, 26'h000_0100);
        neg();
        check("jal_redirect", {31'h0, redirect}, 32'h1);
        cyc();
        set_res(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        neg();
        check("discard_addr", imem_addr, 32'h14);
        check("discard_req", {31'h0, imem_req}, 32'h1);
        cyc();
        man_ack = 1'b1;
        exp_ack.push_back(32'h14);
        neg();
        cyc();
        man_ack = 1'b0;
        neg();
        check("jal_valid", {31'h0, if_valid}, 32'h0);
        check("jal_addr", imem_addr, 32'h4000_0400);

        // BEQ taken in the same cycle as the ack.
        cyc();
        man_ack = 1'b1;
        exp_ack.push_back(32'h4000_0400);
        set_res(1, 1, 0, 0, 1, 32'h0000_0010, 16'hFFFC, 26'h0);
        neg();
        check("beq_redirect", {31'h0, redirect}, 32'h1);
        cyc();
        man_ack = 1'b0;
        set_res(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        neg();
        check("beq_valid", {31'h0, if_valid}, 32'h0);
        check("beq_addr", imem_addr, 32'h0);

        // Second redirect while discarding overwrites the pending target.
        cyc();
        set_res(1, 0, 0, 1, 0, 32'h4000_0004, 16'h0, 26'h000_0100);
        neg();
        cyc();
        set_res(1, 0, 1, 0, 0, 32'h0000_1000, 16'h0010, 26'h0);
        neg();
        check("bne_redirect", {31'h0, redirect}, 32'h1);
        cyc();
        set_res(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        man_ack = 1'b1;
        exp_ack.push_back(32'h0);
        neg();
        cyc();
        man_ack = 1'b0;
        neg();
        check("overwrite_addr", imem_addr, 32'h1040);
        check("overwrite_valid", {31'h0, if_valid}, 32'h0);

        // Redirect while presenting to a ready decoder: no hand-off.
        cyc();
        man_ack = 1'b1;
        exp_ack.push_back(32'h1040);
        neg();
        cyc();
        man_ack = 1'b0;
        set_res(1, 1, 0, 0, 1, 32'h0000_2000, 16'h0001, 26'h0);
        neg();
        check("holdred_valid", {31'h0, if_valid}, 32'h1);
        check("holdred_redirect", {31'h0, redirect}, 32'h1);
        cyc();
        set_res(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0);
        neg();
        check("holdred_drop", {31'h0, if_valid}, 32'h0);
        check("holdred_addr", imem_addr, 32'h2004);
        cyc();
        man_ack = 1'b1;
        exp_ack.push_back(32'h2004);
        push_hand(32'h2004);
        neg();
        cyc();
        man_ack = 1'b0;
        neg();
        cyc();
        neg();
        check("after_hand_addr", imem_addr, 32'h2008);

        // Reset in the middle of a request.
        cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        check("midrst_valid", {31'h0, if_valid}, 32'h0);
        cyc();
        rst_n   = 1'b1;
        man_ack = 1'b1;
        neg();
        check("restart_idle", {31'h0, imem_req}, 32'h0);
        cyc();
        man_ack = 1'b0;
        neg();
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_valid", {31'h0, if_valid}, 32'h0);

        // Wrap-around instance.
        check("wrap_log", log2.size(), 2);
        if (log2.size() >= 2) begin
            check("wrap_addr0", log2[0], 32'hFFFF_FFFC);
            check("wrap_addr1", log2[1], 32'h0000_0000);
        end
        check("wrap_pc4", first_pc4_2, 32'h0);

        check("ack_queue_left", exp_ack.size(), 0);
        check("hand_queue_left", exp_hand.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
